alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the operand and result width.
REQ-002 The block SHALL have parameter OPCODE_LENGTH, default 4, meaning the ALU Operation code width.
REQ-003 The block SHALL have parameter NUM_REQ, default 2, meaning the requester count; only 2 is supported.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operation request.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept strobe.
REQ-008 The block SHALL have port req_srca, input, NUM_REQ x DATA_WIDTH: per-requester SrcA operand.
REQ-009 The block SHALL have port req_srcb, input, NUM_REQ x DATA_WIDTH: per-requester SrcB operand.
REQ-010 The block SHALL have port req_op, input, NUM_REQ x OPCODE_LENGTH: per-requester ALU Operation code.
REQ-011 The block SHALL have port rsp_valid, output, NUM_REQ bits: result available for that requester.
REQ-012 The block SHALL have port rsp_ready, input, NUM_REQ bits: requester consumes its result.
REQ-013 The block SHALL have port rsp_result, output, DATA_WIDTH: registered ALU result, shared by all requesters.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, EXEC and RESP.
REQ-016 In IDLE, req_ready SHALL be one-hot on the granted requester when any req_valid is high, and all-zero otherwise.
REQ-017 Grant SHALL be round-robin: with both valid, the requester other than last_grant wins; with one valid, that one wins.
REQ-018 A request SHALL be accepted on a cycle where req_valid[g] and req_ready[g] are both high; that cycle captures srca, srcb, op and g, and the FSM moves IDLE->EXEC.
REQ-019 In EXEC, the single shared ALU instance SHALL evaluate the captured operands, the result SHALL be registered into rsp_result, and the FSM SHALL move EXEC->RESP.
REQ-020 In RESP, rsp_valid[g] SHALL be high and all other rsp_valid bits low; rsp_result SHALL be held stable.
REQ-021 On a cycle where rsp_valid[g] and rsp_ready[g] are both high, the FSM SHALL move RESP->IDLE and last_grant SHALL update to g.
REQ-022 Latency SHALL be fixed: accept at cycle N gives rsp_valid at N+2; peak throughput is one operation per 3 cycles.
REQ-023 req_ready SHALL be all-zero in EXEC and RESP; requests arriving then SHALL wait with no loss.
REQ-024 rsp_ready on a non-granted bit, or in any state other than RESP, SHALL be ignored.
REQ-025 Requesters SHALL hold valid and operands stable until accepted; the block SHALL NOT sample operands outside the accept cycle.
REQ-026 rsp_result SHALL be exactly the ALU result for the captured Operation at DATA_WIDTH bits, with overflow discarded; undefined codes SHALL give whatever the ALU defines (0).

Reset
REQ-027 On rst_n low, the following SHALL hold immediately, regardless of clk: state=IDLE, last_grant=1 (so requester 0 wins first), rsp_result=0, rsp_valid=0, req_ready=0, busy=0.
REQ-028 Reset asserted during EXEC or RESP SHALL discard the operation; no rsp_valid SHALL follow its release.
REQ-029 After rst_n deasserts, the first accept SHALL be possible on the first rising edge of clk.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the ALU Operation code constants (ADD=4'b0010, SUB, AND, OR, ...).
REQ-031 The ALU SHALL be instantiated once as the existing sub-module alu (ports SrcA, SrcB, Operation, ALUResult); no other sub-module is used.
REQ-032 The RTL SHALL be 120-400 lines.

Verification
REQ-033 Single request: req0 valid, ADD, 5+7 -> req_ready[0] at N; rsp_valid[0] with rsp_result=12 at N+2.
REQ-034 Simultaneous requests after reset: req0 ADD 1+1, req1 ADD 2+3 -> req0 served first (2), then req1 (5); next simultaneous pair grants req1 first.
REQ-035 Response backpressure: rsp_ready[0] held low 4 cycles -> rsp_valid[0] and result stay stable, req_ready stays 0, busy stays 1.
REQ-036 Overflow: ADD 32'hFFFF_FFFF+1 -> rsp_result=0.
REQ-037 Reset in EXEC: pulse rst_n low -> outputs at reset values immediately; no rsp_valid afterwards; next request completes normally.
REQ-038 Wrong-bit rsp_ready: rsp_ready[1] high while serving req0 -> stays in RESP until rsp_ready[0].

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM states and ALU operation codes.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2
);
  logic [NUM_REQ-1:0]                    req_valid;
  logic [NUM_REQ-1:0]                    req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_srca;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_srcb;
  logic [NUM_REQ-1:0][OPCODE_LENGTH-1:0] req_op;
  logic [NUM_REQ-1:0]                    rsp_valid;
  logic [NUM_REQ-1:0]                    rsp_ready;
  logic [DATA_WIDTH-1:0]                 rsp_result;
  logic                                  busy;

  modport slave (
    input  req_valid, req_srca, req_srcb, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, busy
  );

  modport master (
    output req_valid, req_srca, req_srcb, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, busy
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; unknown operation codes produce zero.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    ALUResult = '0;
    case (Operation)
      OPCODE_LENGTH'(OP_AND): ALUResult = SrcA & SrcB;
      OPCODE_LENGTH'(OP_OR):  ALUResult = SrcA | SrcB;
      OPCODE_LENGTH'(OP_ADD): ALUResult = SrcA + SrcB;
      OPCODE_LENGTH'(OP_XOR): ALUResult = SrcA ^ SrcB;
      OPCODE_LENGTH'(OP_SLL): ALUResult = SrcA << shamt;
      OPCODE_LENGTH'(OP_SRL): ALUResult = SrcA >> shamt;
      OPCODE_LENGTH'(OP_SUB): ALUResult = SrcA - SrcB;
      OPCODE_LENGTH'(OP_SLT): ALUResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OPCODE_LENGTH'(OP_SRA): ALUResult = $unsigned($signed(SrcA) >>> shamt);
      default:                ALUResult = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; IDLE -> EXEC -> RESP per op.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int NUM_REQ       = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  state_t state_q, state_d;
  logic   last_grant;
  logic   gidx_q, gidx_d;
  logic   accept, rsp_fire;

  logic [NUM_REQ-1:0]       grant;
  logic [DATA_WIDTH-1:0]    cap_a, cap_b, alu_y, result_q;
  logic [OPCODE_LENGTH-1:0] cap_op;

  // Both valid: the one not served last wins; otherwise the lone valid wins.
  always_comb begin
    grant = bus.req_valid;
    if (&bus.req_valid) begin
      grant[0] = last_grant;
      grant[1] = !last_grant;
    end
  end

  assign gidx_d   = grant[1];
  assign accept   = (state_q == IDLE) && (|bus.req_valid);
  assign rsp_fire = (state_q == RESP) && bus.rsp_ready[gidx_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      gidx_q     <= 1'b0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gidx_q <= gidx_d;
        cap_a  <= bus.req_srca[gidx_d];
        cap_b  <= bus.req_srcb[gidx_d];
        cap_op <= bus.req_op[gidx_d];
      end
      if (state_q == EXEC) result_q <= alu_y;
      if (rsp_fire) last_grant <= gidx_q;
    end
  end

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .SrcA      (cap_a),
    .SrcB      (cap_b),
    .Operation (cap_op),
    .ALUResult (alu_y)
  );

  // Ready is forced low while reset is held so it reads zero without a clock.
  assign bus.req_ready  = (rst_n && state_q == IDLE) ? grant : '0;
  assign bus.rsp_result = result_q;
  assign bus.busy       = (state_q != IDLE);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign bus.rsp_valid[i] = (state_q == RESP) && (gidx_q == 1'(i));
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant order, latency, backpressure, overflow, reset mid-op.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_arbiter_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .NUM_REQ(2)) bus();

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .NUM_REQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] o0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] o1);
    bus.req_valid   = v;
    bus.req_srca[0] = a0; bus.req_srcb[0] = b0; bus.req_op[0] = o0;
    bus.req_srca[1] = a1; bus.req_srcb[1] = b1; bus.req_op[1] = o1;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 2'b00;
    set_req(2'b11, 32'd1, 32'd1, OP_ADD, 32'd2, 32'd3, OP_ADD);
    #2;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_busy",      bus.busy, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_result",    bus.rsp_result, 32'd0);

    // Simultaneous requests: req0 first after reset
    cyc(); rst_n = 1'b1; #1;
    chk("rr_first_grant", bus.req_ready, 2'b01);
    cyc();
    chk("exec_busy",      bus.busy, 1'b1);
    chk("exec_req_ready", bus.req_ready, 2'b00);
    chk("exec_rsp_valid", bus.rsp_valid, 2'b00);
    set_req(2'b11, 32'd10, 32'd3, OP_SUB, 32'd2, 32'd3, OP_ADD);
    cyc();
    chk("r0_rsp_valid", bus.rsp_valid, 2'b01);
    chk("r0_result",    bus.rsp_result, 32'd2);
    chk("resp_req_ready", bus.req_ready, 2'b00);
    bus.rsp_ready = 2'b01;
    cyc();
    chk("rr_second_grant", bus.req_ready, 2'b10);
    chk("idle_rsp_valid",  bus.rsp_valid, 2'b00);
    bus.rsp_ready = 2'b00;
    cyc();
    set_req(2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h3C, OP_AND);
    cyc();
    chk("r1_rsp_valid", bus.rsp_valid, 2'b10);
    chk("r1_result",    bus.rsp_result, 32'd5);
    bus.rsp_ready = 2'b10;
    cyc();
    chk("rr_third_grant", bus.req_ready, 2'b01);
    bus.rsp_ready = 2'b00;
    cyc();
    set_req(2'b10, 32'd0, 32'd0, OP_ADD, 32'hF0, 32'h3C, OP_AND);
    cyc();
    chk("sub_rsp_valid", bus.rsp_valid, 2'b01);
    chk("sub_result",    bus.rsp_result, 32'd7);
    bus.rsp_ready = 2'b01;
    cyc();
    chk("lone_r1_grant", bus.req_ready, 2'b10);
    bus.rsp_ready = 2'b00;
    cyc();
    set_req(2'b00, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD);
    cyc();
    chk("and_rsp_valid", bus.rsp_valid, 2'b10);
    chk("and_result",    bus.rsp_result, 32'h30);
    bus.rsp_ready = 2'b10;
    cyc();
    chk("idle_busy", bus.busy, 1'b0);
    bus.rsp_ready = 2'b00;

    // Overflow wraps to zero
    set_req(2'b01, 32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0, 32'd0, OP_ADD);
    chk("ovf_grant", bus.req_ready, 2'b01);
    cyc();
    set_req(2'b00, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD);
    cyc();
    chk("ovf_rsp_valid", bus.rsp_valid, 2'b01);
    chk("ovf_result",    bus.rsp_result, 32'd0);
    bus.rsp_ready = 2'b01;
    cyc();
    bus.rsp_ready = 2'b00;

    // Single request 5+7, then backpressure with wrong-bit rsp_ready
    set_req(2'b01, 32'd5, 32'd7, OP_ADD, 32'd9, 32'd9, OP_SUB);
    chk("single_grant", bus.req_ready, 2'b01);
    cyc();
    chk("single_exec_rsp_valid", bus.rsp_valid, 2'b00);
    set_req(2'b10, 32'd0, 32'd0, OP_ADD, 32'd9, 32'd4, OP_SUB);
    cyc();
    chk("single_rsp_valid", bus.rsp_valid, 2'b01);
    chk("single_result",    bus.rsp_result, 32'd12);
    bus.rsp_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_rsp_valid", bus.rsp_valid, 2'b01);
      chk("bp_result",    bus.rsp_result, 32'd12);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      chk("bp_busy",      bus.busy, 1'b1);
    end
    bus.rsp_ready = 2'b01;
    cyc();
    chk("bp_waiter_grant", bus.req_ready, 2'b10);
    bus.rsp_ready = 2'b00;
    cyc();
    set_req(2'b00, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD);
    cyc();
    chk("waiter_rsp_valid", bus.rsp_valid, 2'b10);
    chk("waiter_result",    bus.rsp_result, 32'd5);
    bus.rsp_ready = 2'b10;
    cyc();
    bus.rsp_ready = 2'b00;

    // Reset during EXEC discards the operation
    set_req(2'b01, 32'd3, 32'd4, OP_XOR, 32'd0, 32'd0, OP_ADD);
    cyc();
    set_req(2'b00, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD);
    chk("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",      bus.busy, 1'b0);
    chk("mid_rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("mid_rst_result",    bus.rsp_result, 32'd0);
    chk("mid_rst_req_ready", bus.req_ready, 2'b00);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_rsp_valid", bus.rsp_valid, 2'b00);
      chk("post_rst_busy",      bus.busy, 1'b0);
    end

    // After reset req0 wins again; undefined op yields zero
    set_req(2'b11, 32'd6, 32'd3, OP_OR, 32'd123, 32'd456, 4'b1111);
    chk("post_rst_grant", bus.req_ready, 2'b01);
    cyc();
    set_req(2'b10, 32'd0, 32'd0, OP_ADD, 32'd123, 32'd456, 4'b1111);
    cyc();
    chk("or_rsp_valid", bus.rsp_valid, 2'b01);
    chk("or_result",    bus.rsp_result, 32'd7);
    bus.rsp_ready = 2'b01;
    cyc();
    chk("undef_grant", bus.req_ready, 2'b10);
    bus.rsp_ready = 2'b00;
    cyc();
    set_req(2'b00, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD);
    cyc();
    chk("undef_rsp_valid", bus.rsp_valid, 2'b10);
    chk("undef_result",    bus.rsp_result, 32'd0);
    bus.rsp_ready = 2'b10;
    cyc();
    chk("final_busy", bus.busy, 1'b0);
    bus.rsp_ready = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
